// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFillI,
    StFillD
  } arb_state_e;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
  localparam int unsigned WORD_IDX_W  = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter, bundled with arbiter/environment views.
interface mem_arbiter_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 16
);
    logic              i_miss_req;
    logic [AWIDTH-1:0] i_miss_addr;
    logic              d_miss_req;
    logic [AWIDTH-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [AWIDTH-1:0] d_wr_addr;
    logic [DWIDTH-1:0] d_wr_data;
    logic              i_fill_valid;
    logic              d_fill_valid;
    logic [2:0]        fill_idx;
    logic [DWIDTH-1:0] fill_data;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_ack;
    logic              mem_en;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              busy;

    // Arbiter view.
    modport slave (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        output i_fill_valid, d_fill_valid, fill_idx, fill_data, i_fill_done, d_fill_done,
        output d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    // Caches plus memory view.
    modport master (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        input  i_fill_valid, d_fill_valid, fill_idx, fill_data, i_fill_done, d_fill_done,
        input  d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/fill_sequencer.sv
// Block-fill address generator: holds the block base, the issue counter and the receive counter.
module fill_sequencer
    import mem_arb_pkg::*;
#(
    parameter int unsigned AWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  run,
    input  logic [AWIDTH-1:0]     base_in,
    input  logic                  mem_rvalid,
    output logic                  issue_en,
    output logic [AWIDTH-1:0]     issue_addr,
    output logic [WORD_IDX_W-1:0] rcv_idx,
    output logic                  last_word
);
    logic [AWIDTH-1:0]     base_q;
    logic [WORD_IDX_W:0]   iss_q;   // 0..8; MSB set means all reads issued
    logic [WORD_IDX_W-1:0] rcv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            iss_q  <= '0;
            rcv_q  <= '0;
        end else if (start) begin
            base_q <= base_in;
            iss_q  <= '0;
            rcv_q  <= '0;
        end else if (run) begin
            if (issue_en)   iss_q <= iss_q + 1'b1;
            if (mem_rvalid) rcv_q <= rcv_q + 1'b1;
        end
    end

    assign issue_en   = run && !iss_q[WORD_IDX_W];
    assign issue_addr = base_q |
        {{(AWIDTH-WORD_IDX_W-1){1'b0}}, iss_q[WORD_IDX_W-1:0], 1'b0};
    assign rcv_idx    = rcv_q;
    assign last_word  = &rcv_q;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-miss, D-miss and D-store traffic onto one pipelined memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    arb_state_e            state_q;
    logic                  busy_q;
    logic                  in_fill;
    logic                  is_wr;
    logic                  fill_rvalid;
    logic                  start;
    logic [AWIDTH-1:0]     base_in;
    logic                  issue_en;
    logic [AWIDTH-1:0]     issue_addr;
    logic [WORD_IDX_W-1:0] rcv_idx;
    logic                  last_word;

    assign in_fill     = (state_q == StFillI) || (state_q == StFillD);
    assign is_wr       = (state_q == StWrite);
    assign fill_rvalid = in_fill && bus.mem_rvalid;
    // A miss grant happens only when no store outranks it.
    assign start       = (state_q == StIdle) && !bus.d_wr_req &&
                         (bus.d_miss_req || bus.i_miss_req);
    assign base_in     = (bus.d_miss_req ? bus.d_miss_addr : bus.i_miss_addr) &
                         AWIDTH'(BLOCK_MASK);

    fill_sequencer #(
        .AWIDTH (AWIDTH)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .run        (in_fill),
        .base_in    (base_in),
        .mem_rvalid (fill_rvalid),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rcv_idx    (rcv_idx),
        .last_word  (last_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.d_wr_req) begin
                        state_q <= StWrite;
                        busy_q  <= 1'b1;
                    end else if (bus.d_miss_req) begin
                        state_q <= StFillD;
                        busy_q  <= 1'b1;
                    end else if (bus.i_miss_req) begin
                        state_q <= StFillI;
                        busy_q  <= 1'b1;
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StFillI, StFillD: begin
                    if (fill_rvalid && last_word) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_en       = is_wr || issue_en;
        bus.mem_wr       = is_wr;
        bus.mem_addr     = is_wr ? bus.d_wr_addr : (issue_en ? issue_addr : '0);
        bus.mem_wdata    = is_wr ? bus.d_wr_data : {DWIDTH{1'b0}};
        bus.d_wr_ack     = is_wr;
        bus.i_fill_valid = fill_rvalid && (state_q == StFillI);
        bus.d_fill_valid = fill_rvalid && (state_q == StFillD);
        bus.fill_idx     = in_fill ? rcv_idx : '0;
        bus.fill_data    = fill_rvalid ? bus.mem_rdata : '0;
        bus.i_fill_done  = bus.i_fill_valid && last_word;
        bus.d_fill_done  = bus.d_fill_valid && last_word;
        bus.busy         = busy_q;
    end
endmodule
